// File: rtl/rgb_seq_pkg.sv
`default_nettype none
// ============================================================================
// rgb_seq_pkg - parser states, ASCII byte codes and {R,G,B} colour codes
// Revision: 1.0
// ============================================================================
package rgb_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GOT_CH    = 2'd1,
    ST_GOT_COLOR = 2'd2
  } seq_state_e;

  localparam logic [7:0] C_CH_1 = 8'h31, C_CH_2 = 8'h32, C_CH_ALL = 8'h2A;
  localparam logic [7:0] C_CR = 8'h0D, C_LF = 8'h0A;
  localparam logic [7:0] C_DIG_0 = 8'h30, C_DIG_9 = 8'h39;
  localparam logic [7:0] C_ASC_R = 8'h72, C_ASC_G = 8'h67, C_ASC_B = 8'h62, C_ASC_C = 8'h63;
  localparam logic [7:0] C_ASC_M = 8'h6D, C_ASC_Y = 8'h79, C_ASC_W = 8'h77, C_ASC_K = 8'h6B;

  localparam logic [2:0] C_RGB_RED = 3'b100, C_RGB_GREEN = 3'b010, C_RGB_BLUE = 3'b001;
  localparam logic [2:0] C_RGB_CYAN = 3'b011, C_RGB_MAGENTA = 3'b101, C_RGB_YELLOW = 3'b110;
  localparam logic [2:0] C_RGB_WHITE = 3'b111, C_RGB_OFF = 3'b000;

  typedef struct packed {
    logic       valid;
    logic [2:0] rgb;
  } color_dec_t;

  function automatic color_dec_t decode_color(input logic [7:0] b);
    color_dec_t d;
    d.valid = 1'b1;
    case (b)
      C_ASC_R: d.rgb = C_RGB_RED;
      C_ASC_G: d.rgb = C_RGB_GREEN;
      C_ASC_B: d.rgb = C_RGB_BLUE;
      C_ASC_C: d.rgb = C_RGB_CYAN;
      C_ASC_M: d.rgb = C_RGB_MAGENTA;
      C_ASC_Y: d.rgb = C_RGB_YELLOW;
      C_ASC_W: d.rgb = C_RGB_WHITE;
      C_ASC_K: d.rgb = C_RGB_OFF;
      default: begin
        d.valid = 1'b0;
        d.rgb   = C_RGB_OFF;
      end
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_blink_timer.sv
`default_nettype none
// ============================================================================
// rgb_blink_timer - per-LED rate register, blink counter and on/off phase
// Revision: 1.0
// ============================================================================
module rgb_blink_timer #(
  parameter int unsigned BLINK_BASE_CYC = 1200000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] rate_i,
  output logic       phase_o
);

  localparam int CNT_W = $clog2(9 * BLINK_BASE_CYC + 1);

  logic [3:0]       rate_q, rate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] term;
  logic             phase_q, phase_d;

  assign term = CNT_W'(rate_q) * CNT_W'(BLINK_BASE_CYC) - CNT_W'(1);

  // Rate 0 freezes the counter and keeps whatever phase the last load set.
  always_comb begin
    rate_d  = rate_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (load_i) begin
      rate_d  = rate_i;
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (rate_q != 4'd0) begin
      if (cnt_q == term) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rate_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      rate_q  <= rate_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule
`default_nettype wire

// File: rtl/rgb_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// rgb_cmd_sequencer - 3-byte command parser driving two blinking RGB LEDs;
// define RGB_SEQ_TIMEOUT_EN to enable the inter-byte timeout.
// Revision: 1.0
// ============================================================================
module rgb_cmd_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 12000000,
  parameter int unsigned BLINK_BASE_CYC = 1200000,
  parameter int unsigned TIMEOUT_CYC    = 1200000
) (
  input  logic       int_clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_data_ready,
  output logic       rgb1_red,
  output logic       rgb1_green,
  output logic       rgb1_blue,
  output logic       rgb2_red,
  output logic       rgb2_green,
  output logic       rgb2_blue,
  output logic       cmd_ack,
  output logic       cmd_err
);

  if (CLK_FREQ == 0 || BLINK_BASE_CYC == 0 || TIMEOUT_CYC == 0) begin : g_bad_params
    $error("rgb_cmd_sequencer: CLK_FREQ, BLINK_BASE_CYC and TIMEOUT_CYC must be non-zero");
  end

  seq_state_e state_q, state_d;
  logic [1:0] ch_q, ch_d;
  logic [2:0] pend_q, pend_d;
  logic       ack_d, err_d, ack_q, err_q;
  logic [1:0] load;
  logic [1:0] phase;
  logic [2:0] color1_q, color2_q, led1_q, led2_q;
  logic       tmo_expire;
  logic       is_ch, is_crlf, is_rate;
  logic [1:0] ch_sel;
  color_dec_t cdec;

  always_comb begin
    is_crlf = (rx_data == C_CR) || (rx_data == C_LF);
    is_rate = (rx_data >= C_DIG_0) && (rx_data <= C_DIG_9);
    cdec    = decode_color(rx_data);
    case (rx_data)
      C_CH_1:   ch_sel = 2'b01;
      C_CH_2:   ch_sel = 2'b10;
      C_CH_ALL: ch_sel = 2'b11;
      default:  ch_sel = 2'b00;
    endcase
    is_ch = |ch_sel;
  end

`ifdef RGB_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge int_clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (state_q == ST_IDLE || rx_data_ready) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  // A byte in the expiry cycle wins; the expiry path is only taken when idle.
  assign tmo_expire = (state_q != ST_IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge int_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    pend_d  = pend_q;
    if (rx_data_ready) begin
      case (state_q)
        ST_IDLE: begin
          if (is_ch) begin
            ch_d    = ch_sel;
            state_d = ST_GOT_CH;
          end
        end
        ST_GOT_CH: begin
          pend_d  = cdec.rgb;
          state_d = cdec.valid ? ST_GOT_COLOR : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_expire) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    ack_d = 1'b0;
    err_d = 1'b0;
    load  = 2'b00;
    if (rx_data_ready) begin
      case (state_q)
        ST_IDLE:   err_d = !is_ch && !is_crlf;
        ST_GOT_CH: err_d = !cdec.valid;
        ST_GOT_COLOR: begin
          if (is_rate) begin
            ack_d = 1'b1;
            load  = ch_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end else begin
      err_d = tmo_expire;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    rgb_blink_timer #(
      .BLINK_BASE_CYC(BLINK_BASE_CYC)
    ) u_blink (
      .clk_i  (int_clk),
      .rst_i  (rst),
      .load_i (load[gi]),
      .rate_i (rx_data[3:0]),
      .phase_o(phase[gi])
    );
  end

  always_ff @(posedge int_clk or posedge rst) begin
    if (rst) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      color1_q <= '0;
      color2_q <= '0;
      led1_q   <= '0;
      led2_q   <= '0;
    end else begin
      ack_q  <= ack_d;
      err_q  <= err_d;
      if (load[0]) color1_q <= pend_q;
      if (load[1]) color2_q <= pend_q;
      led1_q <= color1_q & {3{phase[0]}};
      led2_q <= color2_q & {3{phase[1]}};
    end
  end

  assign {rgb1_red, rgb1_green, rgb1_blue} = led1_q;
  assign {rgb2_red, rgb2_green, rgb2_blue} = led2_q;
  assign cmd_ack = ack_q;
  assign cmd_err = err_q;

endmodule
`default_nettype wire

// File: doc/rgb_cmd_sequencer.md
RGB_CMD_SEQUENCER -- requirements
Module: rgb_cmd_sequencer

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12000000, meaning int_clk frequency in Hz.
REQ-002 SHALL have parameter BLINK_BASE_CYC, default 1200000, meaning blink time unit in cycles (100 ms).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1200000, meaning maximum idle cycles between bytes of one frame.
REQ-004 SHALL have port int_clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-006 SHALL have port rx_data, input, 8, received byte, valid only while rx_data_ready=1.
REQ-007 SHALL have port rx_data_ready, input, 1, one-cycle strobe per received byte; no back-pressure.
REQ-008 SHALL have ports rgb1_red, rgb1_green, rgb1_blue, output, 1 each, LED 1 drive, active-high, registered.
REQ-009 SHALL have ports rgb2_red, rgb2_green, rgb2_blue, output, 1 each, LED 2 drive, active-high, registered.
REQ-010 SHALL have port cmd_ack, output, 1, one-cycle pulse when a frame is applied.
REQ-011 SHALL have port cmd_err, output, 1, one-cycle pulse when a frame is rejected or times out.

Function
REQ-012 SHALL parse 3-byte frames: channel ('1','2','*'=both), color, rate ('0'..'9').
REQ-013 SHALL map color bytes r=100, g=010, b=001, c=011, m=101, y=110, w=111, k=000 ({R,G,B}).
REQ-014 SHALL run FSM IDLE -> GOT_CH (valid channel) -> GOT_COLOR (valid color) -> IDLE (valid rate, apply).
REQ-015 SHALL, in IDLE, silently drop 0x0D and 0x0A; any other invalid byte in any state pulses cmd_err and returns to IDLE.
REQ-016 SHALL, for a valid rate byte accepted in cycle N, update the addressed channel(s) and pulse cmd_ack in cycle N+1.
REQ-017 SHALL, on apply, clear the channel blink counter and set blink phase to 1 (LED on) in the same cycle.
REQ-018 SHALL treat rate 0 as steady on (phase held at 1); rate n>0 toggles phase every n*BLINK_BASE_CYC cycles.
REQ-019 SHALL count 0..n*BLINK_BASE_CYC-1, toggle phase on the terminal count, and wrap to 0 in the same cycle.
REQ-020 SHALL leave the non-addressed channel's color, rate, counter and phase untouched.
REQ-021 SHALL drive each LED output = registered (phase AND color bit), updated one cycle after phase/color change.
REQ-022 SHALL run the inter-byte timer only in GOT_CH/GOT_COLOR; at TIMEOUT_CYC it pulses cmd_err and returns to IDLE.
REQ-023 SHALL give priority to a byte arriving in the timeout-expiry cycle: the byte is processed, no cmd_err, timer restarts.
REQ-024 SHALL never assert cmd_ack and cmd_err in the same cycle.

Reset
REQ-025 SHALL on rst=1 immediately force FSM=IDLE, all colors=000, rates=0, counters=0, phases=0, all outputs=0.
REQ-026 SHALL discard any partially received frame on reset, with no ack/err pulse; the first byte after release starts a new frame.

Configuration
REQ-027 SHALL, with RGB_SEQ_TIMEOUT_EN defined, implement REQ-003/REQ-022/REQ-023 inter-byte timeout.
REQ-028 SHALL, without RGB_SEQ_TIMEOUT_EN, omit the timeout counter; partial frames wait indefinitely and TIMEOUT_CYC is unused.

Structure
REQ-029 SHALL place FSM state enum, ASCII byte constants and 3-bit color codes in shared package rgb_seq_pkg.
REQ-030 SHALL implement per-channel counter/phase as sub-module rgb_blink_timer, instantiated twice.

Verification
REQ-031 SHALL test '1','r','0' -> cmd_ack 1 cycle after '0'; rgb1_red=1 steady, LED 2 all 0.
REQ-032 SHALL test '*','c','2' with BLINK_BASE_CYC=10 -> both LEDs green+blue on 20 cycles, off 20, repeating.
REQ-033 SHALL test '2','x' -> cmd_err pulse on 'x', FSM IDLE; following '2','b','0' -> rgb2_blue=1, cmd_ack.
REQ-034 SHALL test with RGB_SEQ_TIMEOUT_EN, TIMEOUT_CYC=50: '1' then 50 idle cycles -> cmd_err, IDLE; byte at cycle 50 -> no err.
REQ-035 SHALL test rst asserted mid-frame after '1','g' -> outputs 0 asynchronously; post-release 'g','0' yields cmd_err only.
REQ-036 SHALL test LED 1 blinking at rate 3, then '2','w','0' -> LED 1 blink phase/count unchanged.
